// File: rtl/emmc_blk_sequencer.sv
// emmc_blk_sequencer: write-then-readback block sweep master for emmc_sm
// with sticky compare/protocol error status.
module emmc_blk_sequencer #(
    parameter int unsigned BLK_CNT    = 2,
    parameter int unsigned TOTAL_BLKS = 1562500,
    parameter int unsigned BLK_BYTES  = 512,
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned BLK_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 go_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [15:0]          err_cnt_o,
    output logic [IDX_W-1:0]     first_err_idx_o,
    output logic                 emmc_start_o,
    output logic                 emmc_we_o,
    output logic [IDX_W-1:0]     emmc_blk_idx_o,
    output logic [BLK_CNT_W-1:0] emmc_blk_cnt_o,
    output logic [7:0]           emmc_dat_o,
    input  logic [7:0]           emmc_dat_i,
    input  logic                 emmc_dvalid_i,
    input  logic                 emmc_ready_i
);
    localparam int unsigned BURST_MAX = BLK_CNT * BLK_BYTES;
    localparam int K_W = ($clog2(BURST_MAX) < 10) ? 10 : $clog2(BURST_MAX);
    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_DATA, RD_WAIT, NEXT, DONE
    } state_t;
    state_t state, state_nxt;
    logic [IDX_W:0] blk_idx, rem, cnt, idx_nxt;
    logic [K_W-1:0] k, k_last;
    logic [7:0] pat;
    logic accept, last, in_data, mismatch, proto_err, clr;
    // Index math is one bit wider than IDX_W so the final advance cannot wrap.
    assign rem       = (IDX_W+1)'(TOTAL_BLKS) - blk_idx;
    assign cnt       = (rem < (IDX_W+1)'(BLK_CNT)) ? rem : (IDX_W+1)'(BLK_CNT);
    assign idx_nxt   = blk_idx + cnt;
    assign k_last    = K_W'(cnt * (IDX_W+1)'(BLK_BYTES) - (IDX_W+1)'(1));
    assign pat       = k[7:0] ^ blk_idx[7:0] ^ {k[9:8], 6'b0};
    assign accept    = emmc_start_o && emmc_ready_i;
    assign last      = k == k_last;
    assign in_data   = state == WR_DATA || state == RD_DATA;
    assign proto_err = emmc_dvalid_i && !in_data;
    assign mismatch  = state == RD_DATA && emmc_dvalid_i && emmc_dat_i != pat;
    assign clr       = go_i && (state == IDLE || state == DONE);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = go_i ? WR_REQ : state;
            WR_REQ:     state_nxt = emmc_ready_i ? WR_DATA : state;
            WR_DATA:    state_nxt = (emmc_dvalid_i && last) ? WR_WAIT : state;
            WR_WAIT:    state_nxt = emmc_ready_i ? RD_REQ : state;
            RD_REQ:     state_nxt = emmc_ready_i ? RD_DATA : state;
            RD_DATA:    state_nxt = (emmc_dvalid_i && last) ? RD_WAIT : state;
            RD_WAIT:    state_nxt = emmc_ready_i ? NEXT : state;
            NEXT:       state_nxt = (idx_nxt >= (IDX_W+1)'(TOTAL_BLKS)) ? DONE : WR_REQ;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state           <= IDLE;
            blk_idx         <= '0;
            k               <= '0;
            err_o           <= 1'b0;
            err_cnt_o       <= '0;
            first_err_idx_o <= '0;
        end else begin
            state <= state_nxt;
            if (clr)
                blk_idx <= '0;
            else if (state == NEXT)
                blk_idx <= idx_nxt;
            if (accept)
                k <= '0;
            else if (in_data && emmc_dvalid_i)
                k <= k + K_W'(1);
            if (clr) begin
                err_o           <= 1'b0;
                err_cnt_o       <= '0;
                first_err_idx_o <= '0;
            end else begin
                if (mismatch || proto_err)
                    err_o <= 1'b1;
                if (mismatch && err_cnt_o != 16'hFFFF)
                    err_cnt_o <= err_cnt_o + 16'd1;
                if (mismatch && !err_o)
                    first_err_idx_o <= blk_idx[IDX_W-1:0];
            end
        end
    end
    assign busy_o         = state != IDLE && state != DONE;
    assign done_o         = state == DONE;
    assign emmc_start_o   = state == WR_REQ || state == RD_REQ;
    assign emmc_we_o      = state == WR_REQ || state == WR_DATA || state == WR_WAIT;
    assign emmc_blk_idx_o = blk_idx[IDX_W-1:0];
    assign emmc_blk_cnt_o = busy_o ? BLK_CNT_W'(cnt) : '0;
    assign emmc_dat_o     = (state == WR_DATA) ? pat : 8'd0;
endmodule

// File: tb/tb_emmc_blk_sequencer.sv
// tb_emmc_blk_sequencer: randomized eMMC responder plus burst scoreboard
// for a 5-block sweep of 2-block bursts.
module tb_emmc_blk_sequencer;
    localparam int TOTAL = 5, BC = 2, BB = 512, IW = 32, CW = 16;
    typedef struct packed {logic we; int idx; int cnt;} burst_t;

    logic clk_i = 1'b0, arst_ni = 1'b0, go_i = 1'b0;
    logic busy_o, done_o, err_o, emmc_start_o, emmc_we_o;
    logic [15:0] err_cnt_o;
    logic [IW-1:0] first_err_idx_o, emmc_blk_idx_o;
    logic [CW-1:0] emmc_blk_cnt_o;
    logic [7:0] emmc_dat_o;
    logic [7:0] emmc_dat_i = 8'd0;
    logic emmc_dvalid_i = 1'b0, emmc_ready_i = 1'b1;

    burst_t exp_q[$];
    logic [7:0] mem [TOTAL*BB];
    int n_checks = 0, n_fail = 0;
    int corrupt_idx = -1, corrupt_byte = -1, n_corrupt = 0, first_corrupt = -1, rd_pos = 0;
    bit rand_corrupt = 0, hold_wr = 0, spur_wr = 0, spur_seen = 0, rd_active = 0;

    emmc_blk_sequencer #(.BLK_CNT(BC), .TOTAL_BLKS(TOTAL), .BLK_BYTES(BB), .IDX_W(IW), .BLK_CNT_W(CW)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .go_i(go_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
        .emmc_start_o(emmc_start_o), .emmc_we_o(emmc_we_o), .emmc_blk_idx_o(emmc_blk_idx_o),
        .emmc_blk_cnt_o(emmc_blk_cnt_o), .emmc_dat_o(emmc_dat_o), .emmc_dat_i(emmc_dat_i),
        .emmc_dvalid_i(emmc_dvalid_i), .emmc_ready_i(emmc_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int j, input int b);
        int v;
        v = j ^ b ^ (((j >> 8) & 3) << 6);
        return v[7:0];
    endfunction

    task automatic finish_sim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Ideal eMMC: consumes/produces one byte per dvalid with random gaps, backed by a byte memory.
    task automatic run_burst(input logic we, input int idx, input int cnt);
        logic [7:0] d;
        int a;
        for (int j = 0; j < cnt * BB; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                emmc_dvalid_i = 1'b0;
                @(posedge clk_i); #1;
                if (!arst_ni) return;
            end
            emmc_dvalid_i = 1'b1;
            a = idx * BB + j;
            if (we) begin
                check("wr_byte", {56'd0, emmc_dat_o}, {56'd0, pat(j, idx)});
                mem[a] = emmc_dat_o;
            end else begin
                d = mem[a];
                if ((idx == corrupt_idx && j == corrupt_byte) || (rand_corrupt && $urandom_range(0, 299) == 0)) begin
                    d ^= 8'h5A;
                    n_corrupt++;
                    if (first_corrupt < 0) first_corrupt = idx;
                end
                emmc_dat_i = d;
                rd_active = 1'b1;
                rd_pos = j;
            end
            @(posedge clk_i); #1;
            if (!arst_ni) return;
        end
        emmc_dvalid_i = 1'b0;
        rd_active = 1'b0;
        if (we && spur_wr) begin
            spur_wr = 1'b0;
            spur_seen = 1'b1;
            emmc_dvalid_i = 1'b1;
            @(posedge clk_i); #1;
            emmc_dvalid_i = 1'b0;
            if (!arst_ni) return;
        end
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk_i); #1;
            if (!arst_ni) return;
        end
    endtask

    initial begin : model
        logic w;
        int b, c;
        bit held;
        forever begin
            @(posedge clk_i); #1;
            if (!arst_ni) begin
                emmc_dvalid_i = 1'b0;
                emmc_ready_i = 1'b1;
                continue;
            end
            if (emmc_start_o && emmc_ready_i) begin
                held = 1'b0;
                if (hold_wr && emmc_we_o && emmc_blk_idx_o == 2) begin
                    held = 1'b1;
                    hold_wr = 1'b0;
                    emmc_ready_i = 1'b0;
                    repeat (100) begin
                        @(posedge clk_i); #1;
                        check("hold_start", {29'd0, emmc_start_o, emmc_we_o, busy_o, emmc_blk_idx_o}, {29'd0, 3'b111, 32'd2});
                    end
                    emmc_ready_i = 1'b1;
                end
                w = emmc_we_o;
                b = int'(emmc_blk_idx_o);
                c = int'(emmc_blk_cnt_o);
                @(posedge clk_i); #1;
                if (!arst_ni) continue;
                if (held) check("hold_release_accept", {63'd0, emmc_start_o}, 64'd0);
                emmc_ready_i = 1'b0;
                run_burst(w, b, c);
                emmc_dvalid_i = 1'b0;
                emmc_ready_i = 1'b1;
                rd_active = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin : monitor
        burst_t e;
        if (arst_ni && emmc_start_o && emmc_ready_i) begin
            if (exp_q.size() == 0)
                check("burst_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("burst_req", {15'd0, emmc_we_o, emmc_blk_idx_o, emmc_blk_cnt_o},
                      {15'd0, e.we, e.idx[31:0], e.cnt[15:0]});
            end
        end
    end

    task automatic push_sweep();
        int c;
        for (int b = 0; b < TOTAL; b += BC) begin
            c = (TOTAL - b < BC) ? TOTAL - b : BC;
            exp_q.push_back('{we: 1'b1, idx: b, cnt: c});
            exp_q.push_back('{we: 1'b0, idx: b, cnt: c});
        end
    endtask

    task automatic pulse_go();
        @(posedge clk_i); #1;
        go_i = 1'b1;
        @(posedge clk_i); #1;
        go_i = 1'b0;
    endtask

    task automatic sweep(input string name, input bit go_busy);
        int n;
        n_corrupt = 0;
        first_corrupt = -1;
        spur_seen = 1'b0;
        push_sweep();
        pulse_go();
        if (go_busy) begin
            repeat (50) @(posedge clk_i);
            #1;
            check({name, "_busy"}, {63'd0, busy_o}, 64'd1);
            go_i = 1'b1;
            @(posedge clk_i); #1;
            go_i = 1'b0;
        end
        n = 0;
        while (!done_o && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_done"}, {63'd0, done_o}, 64'd1);
        if (!done_o) finish_sim();
        @(negedge clk_i);
        check({name, "_busy_end"}, {63'd0, busy_o}, 64'd0);
        check({name, "_err"}, {63'd0, err_o}, {63'd0, (n_corrupt > 0) || spur_seen});
        check({name, "_err_cnt"}, {48'd0, err_cnt_o}, 64'(n_corrupt > 65535 ? 65535 : n_corrupt));
        check({name, "_first_err"}, {32'd0, first_err_idx_o}, 64'(first_corrupt < 0 ? 0 : first_corrupt));
        check({name, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_status"}, {12'd0, busy_o, done_o, err_o, err_cnt_o, first_err_idx_o, emmc_start_o}, 64'd0);
        check({name, "_bus"}, {7'd0, emmc_we_o, emmc_blk_idx_o, emmc_blk_cnt_o, emmc_dat_o}, 64'd0);
    endtask

    initial begin : main
        int n;
        #23;
        check_reset_outputs("reset");
        @(negedge clk_i);
        arst_ni = 1'b1;
        sweep("clean", 1'b0);
        corrupt_idx = 2;
        corrupt_byte = 7;
        sweep("corrupt_b7", 1'b0);
        corrupt_idx = -1;
        corrupt_byte = -1;
        rand_corrupt = 1'b1;
        sweep("rand_corrupt", 1'b0);
        rand_corrupt = 1'b0;
        hold_wr = 1'b1;
        spur_wr = 1'b1;
        sweep("hold_spur", 1'b1);
        check("hold_taken", {63'd0, hold_wr}, 64'd0);
        push_sweep();
        pulse_go();
        n = 0;
        while (!(rd_active && rd_pos >= 20) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        check("reach_rd_data", {63'd0, rd_active}, 64'd1);
        @(negedge clk_i); #2;
        arst_ni = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk_i);
        exp_q.delete();
        arst_ni = 1'b1;
        sweep("after_reset", 1'b0);
        finish_sim();
    end
endmodule
